// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter/sequencer for the single-port memory.
//                Port 0 = instruction fetch (if_), port 1 = load/store (ls_).
//                One transaction at a time: IDLE -> ISSUE -> RESP -> IDLE.
//                Default arbitration is round-robin on a 1-bit last_grant.
//                Define MEM_ARB_LS_PRIO_EN for fixed load/store priority.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module mem_arbiter #(
    parameter int ADDR_W = `REG_SIZE,
    parameter int DATA_W = `REG_SIZE
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_rdata,

    input  logic              ls_req_valid,
    input  logic              ls_req_rw,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_resp_rdata,

    output logic              mem_EN,
    output logic              mem_RW,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Captured transaction; these registers also drive the memory bus so
    // the bus holds its last values outside ISSUE.
    logic              r_owner;   // 0 = fetch, 1 = load/store
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_grant_ls;
    logic w_accept;

`ifdef MEM_ARB_LS_PRIO_EN
    // Fixed priority: load/store wins whenever it is requesting.
    always_comb begin
        w_grant_ls = ls_req_valid;
    end
`else
    logic r_last_grant;

    // Round-robin: on contention the port that did not win last time wins;
    // a lone requester always wins.
    always_comb begin
        w_grant_ls = ls_req_valid & (~if_req_valid | ~r_last_grant);
    end

    // Remember the most recently accepted port; fetch wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant_ls;
        end
    end
`endif

    // A request is accepted only in IDLE and never while reset is asserted,
    // since the capture registers would be cleared at that same edge.
    always_comb begin
        w_accept = (r_state == ST_IDLE) & (if_req_valid | ls_req_valid) & ~rst;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and all FSM-driven outputs.
    always_comb begin
        w_state_next  = r_state;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        if_resp_rdata = '0;
        ls_resp_valid = 1'b0;
        ls_resp_rdata = '0;
        mem_EN        = 1'b0;
        mem_RW        = r_rw;
        mem_addr      = r_addr;
        mem_wdata     = r_wdata;
        busy          = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if_req_ready = w_accept & ~w_grant_ls;
                ls_req_ready = w_accept &  w_grant_ls;
                if (w_accept) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_EN       = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                // Response is combinational so it is still delivered if
                // reset arrives in this cycle.
                if (r_owner) begin
                    ls_resp_valid = 1'b1;
                    ls_resp_rdata = r_rw ? '0 : mem_rdata;
                end else begin
                    if_resp_valid = 1'b1;
                    if_resp_rdata = mem_rdata;
                end
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the winning request at the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_owner <= w_grant_ls;
            if (w_grant_ls) begin
                r_rw    <= ls_req_rw;
                r_addr  <= ls_req_addr;
                r_wdata <= ls_req_wdata;
            end else begin
                // Fetch is always a read and carries no write data.
                r_rw    <= 1'b0;
                r_addr  <= if_req_addr;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed vector table,
//                multi-cycle corner sequences and randomized traffic checked
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_resp_valid;
    logic [DW-1:0] if_resp_rdata;
    logic          ls_req_valid;
    logic          ls_req_rw;
    logic [AW-1:0] ls_req_addr;
    logic [DW-1:0] ls_req_wdata;
    logic          ls_req_ready;
    logic          ls_resp_valid;
    logic [DW-1:0] ls_resp_rdata;
    logic          mem_EN;
    logic          mem_RW;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_resp_valid (if_resp_valid),
        .if_resp_rdata (if_resp_rdata),
        .ls_req_valid  (ls_req_valid),
        .ls_req_rw     (ls_req_rw),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_ready  (ls_req_ready),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_rdata (ls_resp_rdata),
        .mem_EN        (mem_EN),
        .mem_RW        (mem_RW),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Memory environment: single port, registered read, no reset; low 8
    // address bits index a 256-word array. Preloaded on the first edge.
    logic [31:0] mem [0:255];
    bit          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem_loaded <= 1'b1;
        end else if (mem_EN) begin
            if (mem_RW) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // The arbiter is "free" from cycle m_next_free on; an accepted request
    // occupies it for three cycles, is issued one cycle later and answered
    // two cycles later.
    typedef struct {
        int          when;
        bit          port;
        logic [31:0] data;
    } resp_t;

    resp_t       resp_q[$];
    int          m_next_free = 0;
    int          m_issue_cyc = -1;
    bit          m_last      = 1'b1;
    bit          m_iss_rw;
    logic [31:0] m_iss_addr;
    logic [31:0] m_iss_wdata;
    logic [31:0] ref_mem [0:255];

    task automatic model_check();
        bit          exp_busy, exp_en, exp_ifr, exp_lsr, exp_ifv, exp_lsv, win;
        logic [31:0] exp_ifd, exp_lsd, data;
        resp_t       r;
        exp_busy = (cyc < m_next_free);
        exp_en   = (cyc == m_issue_cyc);
        exp_ifv = 1'b0; exp_lsv = 1'b0; exp_ifd = '0; exp_lsd = '0;
        if (resp_q.size() != 0 && resp_q[0].when == cyc) begin
            r = resp_q.pop_front();
            if (r.port) begin exp_lsv = 1'b1; exp_lsd = r.data; end
            else        begin exp_ifv = 1'b1; exp_ifd = r.data; end
        end
        chk1("m_busy", busy, exp_busy);
        chk1("m_mem_EN", mem_EN, exp_en);
        if (exp_en) begin
            chk1("m_mem_RW", mem_RW, m_iss_rw);
            chk32("m_mem_addr", mem_addr, m_iss_addr);
            if (m_iss_rw) chk32("m_mem_wdata", mem_wdata, m_iss_wdata);
        end
        chk1("m_if_resp_valid", if_resp_valid, exp_ifv);
        chk1("m_ls_resp_valid", ls_resp_valid, exp_lsv);
        if (exp_ifv) chk32("m_if_resp_rdata", if_resp_rdata, exp_ifd);
        if (exp_lsv) chk32("m_ls_resp_rdata", ls_resp_rdata, exp_lsd);

        exp_ifr = 1'b0; exp_lsr = 1'b0;
        if (rst) begin
            resp_q.delete();
            m_next_free = cyc + 1;
            m_last      = 1'b1;
        end else if (!exp_busy && (if_req_valid || ls_req_valid)) begin
`ifdef MEM_ARB_LS_PRIO_EN
            win = ls_req_valid;
`else
            if (if_req_valid && ls_req_valid) win = !m_last;
            else                              win = ls_req_valid;
`endif
            if (win) exp_lsr = 1'b1; else exp_ifr = 1'b1;
            m_issue_cyc = cyc + 1;
            m_iss_rw    = win ? ls_req_rw : 1'b0;
            m_iss_addr  = win ? ls_req_addr : if_req_addr;
            m_iss_wdata = ls_req_wdata;
            if (m_iss_rw) begin
                ref_mem[m_iss_addr[7:0]] = m_iss_wdata;
                data = '0;
            end else begin
                data = ref_mem[m_iss_addr[7:0]];
            end
            resp_q.push_back('{cyc + 2, win, data});
            m_next_free = cyc + 3;
            m_last      = win;
        end
        chk1("m_if_req_ready", if_req_ready, exp_ifr);
        chk1("m_ls_req_ready", ls_req_ready, exp_lsr);
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        at_neg();
        finish_cycle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          port;   // 0 = fetch, 1 = load/store
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_vec(input vec_t v);
        if (v.port) begin
            ls_req_valid = 1'b1; ls_req_rw = v.rw;
            ls_req_addr  = v.addr; ls_req_wdata = v.wdata;
        end else begin
            if_req_valid = 1'b1; if_req_addr = v.addr;
        end
        at_neg();
        chk1("vec_ready", v.port ? ls_req_ready : if_req_ready, 1'b1);
        chk1("vec_other_ready", v.port ? if_req_ready : ls_req_ready, 1'b0);
        finish_cycle();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        at_neg();
        chk1("vec_issue_en", mem_EN, 1'b1);
        chk1("vec_issue_rw", mem_RW, v.rw);
        chk32("vec_issue_addr", mem_addr, v.addr);
        finish_cycle();
        at_neg();
        chk1("vec_resp_valid", v.port ? ls_resp_valid : if_resp_valid, 1'b1);
        chk1("vec_other_resp", v.port ? if_resp_valid : ls_resp_valid, 1'b0);
        chk32("vec_resp_rdata", v.port ? ls_resp_rdata : if_resp_rdata, v.exp_rdata);
        finish_cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) a = a | ($urandom & 32'hFFFF_FF00);
        return a;
    endfunction

    initial begin
        vec_t  vecs[6];
        bit    grants[$];
        int    nresp;
        bit    ia, la;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h12345678,  32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h12345678};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FF44, 32'hCAFEF00D,  32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FF44, 32'h0,         32'hCAFEF00D};

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[8'h10] = 32'hDEADBEEF;

        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        ls_req_valid = 1'b0; ls_req_rw = 1'b0; ls_req_addr = '0; ls_req_wdata = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        at_neg();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_EN", mem_EN, 1'b0);
        chk1("rst_if_ready", if_req_ready, 1'b0);
        chk1("rst_ls_ready", ls_req_ready, 1'b0);
        chk1("rst_if_resp", if_resp_valid, 1'b0);
        chk1("rst_ls_resp", ls_resp_valid, 1'b0);
        chk32("rst_if_rdata", if_resp_rdata, 32'h0);
        chk32("rst_ls_rdata", ls_resp_rdata, 32'h0);
        chk1("rst_mem_RW", mem_RW, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        finish_cycle();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Request while busy: ls request raised during ISSUE/RESP of a fetch.
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        at_neg(); chk1("busy_if_ready", if_req_ready, 1'b1); finish_cycle();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b1; ls_req_rw = 1'b0; ls_req_addr = 32'h20;
        at_neg(); chk1("busy_ls_ready_issue", ls_req_ready, 1'b0); finish_cycle();
        at_neg();
        chk1("busy_ls_ready_resp", ls_req_ready, 1'b0);
        chk32("busy_if_rdata", if_resp_rdata, 32'hDEADBEEF);
        finish_cycle();
        at_neg(); chk1("busy_ls_ready_idle", ls_req_ready, 1'b1); finish_cycle();
        ls_req_valid = 1'b0;
        at_neg(); chk32("busy_ls_addr", mem_addr, 32'h20); finish_cycle();
        at_neg();
        chk1("busy_ls_resp", ls_resp_valid, 1'b1);
        chk32("busy_ls_rdata", ls_resp_rdata, 32'h12345678);
        finish_cycle();

        // Reset pulsed during ISSUE of an ls write.
        ls_req_valid = 1'b1; ls_req_rw = 1'b1; ls_req_addr = 32'h30; ls_req_wdata = 32'hA5A5A5A5;
        at_neg(); chk1("rstmid_ready", ls_req_ready, 1'b1); finish_cycle();
        ls_req_valid = 1'b0; ls_req_rw = 1'b0;
        rst = 1'b1;
        at_neg();
        chk1("rstmid_mem_EN", mem_EN, 1'b1);
        chk1("rstmid_mem_RW", mem_RW, 1'b1);
        finish_cycle();
        rst = 1'b0;
        at_neg();
        chk1("rstmid_busy", busy, 1'b0);
        chk1("rstmid_no_resp", ls_resp_valid, 1'b0);
        finish_cycle();
        at_neg(); chk1("rstmid_no_resp_late", ls_resp_valid, 1'b0); finish_cycle();
        run_vec('{1'b1, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5});

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            at_neg();
            chk1("idle_en", mem_EN | if_req_ready | ls_req_ready | if_resp_valid | ls_resp_valid, 1'b0);
            chk1("idle_busy", busy, 1'b0);
            finish_cycle();
        end

        // Both ports valid continuously from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        ls_req_valid = 1'b1; ls_req_rw = 1'b0; ls_req_addr = 32'h20;
        nresp = 0;
        for (int i = 0; i < 12; i++) begin
            at_neg();
            ia = if_req_ready; la = ls_req_ready;
            if (ia) grants.push_back(1'b0);
            if (la) grants.push_back(1'b1);
            if (if_resp_valid || ls_resp_valid) nresp++;
            finish_cycle();
            if (ia) if_req_addr = if_req_addr + 32'h4;
            if (la) ls_req_addr = ls_req_addr + 32'h4;
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        chk32("cont_grants", 32'(grants.size()), 32'd4);
        chk32("cont_resps", 32'(nresp), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_LS_PRIO_EN
            if (i < grants.size()) chk1("cont_order", grants[i], 1'b1);
`else
            if (i < grants.size()) chk1("cont_order", grants[i], (i % 2) == 1);
`endif
        end
        tick();
        tick();

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!if_req_valid && $urandom_range(0, 2) == 0) begin
                if_req_valid = 1'b1;
                if_req_addr  = rand_addr();
            end
            if (!ls_req_valid && $urandom_range(0, 2) == 0) begin
                ls_req_valid = 1'b1;
                ls_req_rw    = 1'($urandom_range(0, 1));
                ls_req_addr  = rand_addr();
                ls_req_wdata = $urandom;
            end
            at_neg();
            ia = if_req_ready; la = ls_req_ready;
            finish_cycle();
            if (ia) if_req_valid = 1'b0;
            if (la) ls_req_valid = 1'b0;
        end
        rst = 1'b0;
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port `memory` block.
- Port 0 is instruction fetch (`if_`); port 1 is load/store (`ls_`).
- Accepts one transaction at a time, drives `mem_EN`/`mem_RW`/`addr`/`wdata` to the memory, captures the registered `rdata`, and returns a response pulse to the owning requester.
- Sits between the core pipeline and `memory`.

Parameters:
- `ADDR_W`, default `REG_SIZE`: requester and memory address width.
- `DATA_W`, default `REG_SIZE`: read/write data width.

Ports:
- `clk`  in  1  the only clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req_valid`  in  1  fetch request pending.
- `if_req_addr`  in  `ADDR_W`  fetch address; fetch is always a read.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_resp_valid`  out  1  one-cycle pulse; `if_resp_rdata` valid.
- `if_resp_rdata`  out  `DATA_W`  fetched word.
- `ls_req_valid`  in  1  load/store request pending.
- `ls_req_rw`  in  1  0 = read, 1 = write (same encoding as `mem_RW`).
- `ls_req_addr`  in  `ADDR_W`  load/store address.
- `ls_req_wdata`  in  `DATA_W`  store data.
- `ls_req_ready`  out  1  load/store request accepted this cycle.
- `ls_resp_valid`  out  1  one-cycle pulse; read data or write acknowledge.
- `ls_resp_rdata`  out  `DATA_W`  loaded word; 0 for write acknowledge.
- `mem_EN`  out  1  memory enable.
- `mem_RW`  out  1  memory read/write select.
- `mem_addr`  out  `ADDR_W`  memory address.
- `mem_wdata`  out  `DATA_W`  memory write data.
- `mem_rdata`  in  `DATA_W`  memory read data, valid one cycle after a read issue.
- `busy`  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- **IDLE:**
  - If any `req_valid` is high, the arbitration winner sees its `req_ready` high, combinationally in the same cycle.
  - The loser's `req_ready` is 0.
  - At the edge the arbiter registers winner id, rw, addr, wdata and moves to ISSUE.
  - With no request, it stays in IDLE.
- **ISSUE** (exactly 1 cycle):
  - `mem_EN` = 1; `mem_RW`/`mem_addr`/`mem_wdata` come from the captured registers.
  - The memory performs the access at the closing edge; next state is RESP.
- **RESP** (exactly 1 cycle):
  - The owner's `resp_valid` = 1.
  - Read: `resp_rdata` = `mem_rdata`.
  - Write: `resp_rdata` = 0.
  - Next state is IDLE.
- No back-to-back issue: throughput is one transaction per 3 cycles. Latency from request acceptance edge to `resp_valid` is 2 cycles.
- Requesters have no response backpressure; `resp_valid` is a single-cycle pulse and must be consumed when it arrives.
- `req_ready` is 0 in ISSUE and RESP. A requester holds `valid`/`addr`/`data` stable until it sees `ready`.
- Outside ISSUE:
  - `mem_EN` = 0.
  - `mem_RW`, `mem_addr`, `mem_wdata` hold their last values (0 after reset).
- **Arbitration (default):** round-robin on a 1-bit `last_grant` register.
  - With both valid in IDLE, the port != `last_grant` wins.
  - With one valid, that port wins regardless of `last_grant`.
  - `last_grant` updates only on acceptance.
- **Reset:**
  - State = IDLE, `last_grant` = 1 (fetch wins the first contention).
  - All captured registers = 0.
  - All `ready`/`resp_valid` = 0, `mem_EN` = 0, `busy` = 0, `resp_rdata` outputs = 0.
- **Reset mid-operation:**
  - `rst` sampled high in ISSUE: the access driven that cycle still reaches the memory, because the memory has no reset and sees `mem_EN` = 1 at that edge. The arbiter then returns to IDLE and emits no response.
  - `rst` sampled high in RESP: the response pulse for that cycle is still driven combinationally; state goes to IDLE.
- **Out-of-range addresses:** `mem_addr` is passed through unchanged. Range checking is not performed here.

Optional Feature:
- Macro: `MEM_ARB_LS_PRIO_EN`.
- Defined: fixed priority.
  - `ls` wins whenever `ls_req_valid` = 1 in IDLE; fetch is granted only when `ls_req_valid` = 0.
  - `last_grant` is not implemented.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then fetch `addr` = 0x10 with `mem[0x10]` = 0xDEADBEEF.
  - `if_req_ready` is high the same cycle.
  - `mem_EN` = 1, `mem_RW` = 0 the next cycle.
  - `if_resp_valid` = 1 with 0xDEADBEEF 2 cycles after acceptance.
  - `ls_resp_valid` stays 0.
- ls write `addr` = 0x20, `wdata` = 0x12345678, then ls read 0x20.
  - Write acknowledge pulses with `rdata` = 0.
  - The read returns 0x12345678.
- Both ports valid continuously from reset, 4 transactions.
  - Grant order is if, ls, if, ls.
  - Exactly one `resp_valid` every 3 cycles, routed to the matching port.
  - With `MEM_ARB_LS_PRIO_EN` defined, order is ls, ls, ls, ls.
- Request asserted while busy (in ISSUE/RESP).
  - `req_ready` stays 0.
  - The request is accepted on the first IDLE cycle.
  - `addr` held stable is used unmodified.
- `rst` pulsed during ISSUE of an ls write 0x30 ← 0xA5A5A5A5.
  - No `ls_resp_valid` is produced.
  - `busy` = 0 the next cycle.
  - A later read of 0x30 returns 0xA5A5A5A5.
- Idle with no requests for 10 cycles.
  - `mem_EN`, all `ready` and all `resp_valid` stay 0.
  - `busy` stays 0.
